tia_horizontal_motion_controller: RTL and testbench

Sequences HMOVE for the five movable objects (P0, P1, M0, M1, BL). On an HMOVE strobe it issues a burst of extra position-counter clock enables to each object's position counter via per-object active-low pec_bar. The count per object is set by that object's 4-bit signed horizontal-motion value. It sits between the HMxx register file and the five position counters, and also drives the extended-HBLANK (HMOVE comb) flag.

---
 rtl/tia_hmove_defs.sv | 26 ++
 rtl/tia_horizontal_motion_controller_if.sv | 22 ++
 rtl/tia_hmove_comparator.sv | 35 +++
 rtl/tia_horizontal_motion_controller.sv | 63 ++++++
 tb/tb_tia_horizontal_motion_controller.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tia_hmove_defs.sv
// Shared constants, state encoding and helpers for the HMOVE sequencer.
package tia_hmove_defs;

   localparam int unsigned NUM_OBJ = 5;
   localparam int unsigned HM_W    = 4;
   localparam int unsigned STEPS   = 16;

   localparam int unsigned OBJ_P0 = 0;
   localparam int unsigned OBJ_P1 = 1;
   localparam int unsigned OBJ_M0 = 2;
   localparam int unsigned OBJ_M1 = 3;
   localparam int unsigned OBJ_BL = 4;

   localparam logic [HM_W-1:0] HM_BIAS = 4'b1000;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } hm_state_e;

   // Signed motion value to unsigned pulse count (0..15).
   function automatic logic [HM_W-1:0] pulse_count(input logic [HM_W-1:0] hm);
      return hm ^ HM_BIAS;
   endfunction

endpackage

// File: rtl/tia_horizontal_motion_controller_if.sv
// Bus between the HMxx register file / timing chain and the HMOVE sequencer.
interface tia_horizontal_motion_controller_if;
   import tia_hmove_defs::*;

   logic                     tick;
   logic                     hmove;
   logic                     rhb;
   logic [NUM_OBJ*HM_W-1:0]  hm;
   logic [NUM_OBJ-1:0]       pec_bar;
   logic                     busy;
   logic                     hmove_blank;

   modport master (
      output tick, hmove, rhb, hm,
      input  pec_bar, busy, hmove_blank
   );

   modport slave (
      input  tick, hmove, rhb, hm,
      output pec_bar, busy, hmove_blank
   );
endinterface

// File: rtl/tia_hmove_comparator.sv
// Per-object slice: latches the pulse count and emits one pec_bar pulse per counted step.
module tia_hmove_comparator
   import tia_hmove_defs::*;
(
   input  logic            clk,
   input  logic            reset_bar,
   input  logic            load,
   input  logic [HM_W-1:0] hm_val,
   input  logic            step,
   input  logic [HM_W-1:0] k,
   output logic            pec_bar
);

   logic [HM_W-1:0] m;
   logic            flag;

   // Load on hmove overrides any step in the same cycle, so a restart tick is never counted.
   always_ff @(posedge clk or negedge reset_bar) begin
      if (!reset_bar) begin
         m       <= '0;
         flag    <= 1'b0;
         pec_bar <= 1'b1;
      end else begin
         pec_bar <= 1'b1;
         if (load) begin
            m    <= pulse_count(hm_val);
            flag <= (pulse_count(hm_val) != '0);
         end else if (step && flag) begin
            pec_bar <= 1'b0;
            if ((k + HM_W'(1)) == m) flag <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/tia_horizontal_motion_controller.sv
// HMOVE sequencer: step FSM, shared step counter, extended-blank flag and per-object comparators.
module tia_horizontal_motion_controller
   import tia_hmove_defs::*;
(
   input  logic                               clk,
   input  logic                               reset_bar,
   tia_horizontal_motion_controller_if.slave  bus
);

   localparam logic [HM_W-1:0] K_LAST = HM_W'(STEPS - 1);

   hm_state_e          state;
   logic [HM_W-1:0]    k;
   logic               busy_q;
   logic               blank_q;
   logic               step;
   logic [NUM_OBJ-1:0] pec_bar_w;

   assign step = (state == RUN) && bus.tick && !bus.hmove;

   // busy mirrors the registered state, so it rises the cycle after hmove.
   always_ff @(posedge clk or negedge reset_bar) begin
      if (!reset_bar) begin
         state  <= IDLE;
         k      <= '0;
         busy_q <= 1'b0;
      end else if (bus.hmove) begin
         state  <= RUN;
         k      <= '0;
         busy_q <= 1'b1;
      end else if (step) begin
         k <= k + HM_W'(1);
         if (k == K_LAST) begin
            state  <= IDLE;
            busy_q <= 1'b0;
         end
      end
   end

   // Set wins over clear when hmove and rhb coincide.
   always_ff @(posedge clk or negedge reset_bar) begin
      if (!reset_bar)     blank_q <= 1'b0;
      else if (bus.hmove) blank_q <= 1'b1;
      else if (bus.rhb)   blank_q <= 1'b0;
   end

   for (genvar i = 0; i < NUM_OBJ; i++) begin : g_obj
      tia_hmove_comparator u_cmp (
         .clk       (clk),
         .reset_bar (reset_bar),
         .load      (bus.hmove),
         .hm_val    (bus.hm[i*HM_W +: HM_W]),
         .step      (step),
         .k         (k),
         .pec_bar   (pec_bar_w[i])
      );
   end

   assign bus.pec_bar     = pec_bar_w;
   assign bus.busy        = busy_q;
   assign bus.hmove_blank = blank_q;

endmodule

// File: tb/tb_tia_horizontal_motion_controller.sv
// Testbench for the HMOVE sequencer: directed scenarios plus a randomized run against a burst-level model.
module tb_tia_horizontal_motion_controller;
   import tia_hmove_defs::*;

   logic clk = 1'b0;
   logic reset_bar = 1'b0;

   tia_horizontal_motion_controller_if bus();

   tia_horizontal_motion_controller dut (
      .clk       (clk),
      .reset_bar (reset_bar),
      .bus       (bus.slave)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Burst-level model: how many ticks have been counted and how many pulses each object is owed.
   bit m_active;
   int m_cnt;
   int m_pulses [NUM_OBJ];
   bit m_blank;
   int low_cnt  [NUM_OBJ];
   logic [NUM_OBJ-1:0] exp_pec;

   // Motion value -8..+7 plus the 8 clocks normal HBLANK suppresses.
   function automatic int pulses_of(input logic [HM_W-1:0] v);
      return int'($signed(v)) + 8;
   endfunction

   function automatic logic [NUM_OBJ*HM_W-1:0] pack_hm(input int p0, input int p1,
                                                      input int m0, input int m1, input int bl);
      logic [NUM_OBJ*HM_W-1:0] r;
      r = '0;
      r[OBJ_P0*HM_W +: HM_W] = HM_W'(p0);
      r[OBJ_P1*HM_W +: HM_W] = HM_W'(p1);
      r[OBJ_M0*HM_W +: HM_W] = HM_W'(m0);
      r[OBJ_M1*HM_W +: HM_W] = HM_W'(m1);
      r[OBJ_BL*HM_W +: HM_W] = HM_W'(bl);
      return r;
   endfunction

   // One clock of stimulus, then compare all outputs against the model.
   task automatic cycle(input bit tk, input bit hv, input bit rb,
                        input logic [NUM_OBJ*HM_W-1:0] hmv, input string tag);
      @(negedge clk);
      bus.tick = tk; bus.hmove = hv; bus.rhb = rb; bus.hm = hmv;
      @(posedge clk);
      #1;
      exp_pec = '1;
      if (m_active && tk && !hv)
         for (int i = 0; i < NUM_OBJ; i++)
            if (m_cnt < m_pulses[i]) exp_pec[i] = 1'b0;
      if (hv) begin
         m_active = 1'b1;
         m_cnt    = 0;
         for (int i = 0; i < NUM_OBJ; i++) m_pulses[i] = pulses_of(hmv[i*HM_W +: HM_W]);
      end else if (m_active && tk) begin
         m_cnt++;
         if (m_cnt == int'(STEPS)) m_active = 1'b0;
      end
      if (hv) m_blank = 1'b1;
      else if (rb) m_blank = 1'b0;
      for (int i = 0; i < NUM_OBJ; i++) if (bus.pec_bar[i] === 1'b0) low_cnt[i]++;
      n_cmp++;
      if (bus.pec_bar !== exp_pec) begin
         n_bad++;
         $display("FAIL %s pec_bar: got %b want %b (t=%0t)", tag, bus.pec_bar, exp_pec, $time);
      end
      n_cmp++;
      if (bus.busy !== m_active) begin
         n_bad++;
         $display("FAIL %s busy: got %b want %b (t=%0t)", tag, bus.busy, m_active, $time);
      end
      n_cmp++;
      if (bus.hmove_blank !== m_blank) begin
         n_bad++;
         $display("FAIL %s hmove_blank: got %b want %b (t=%0t)", tag, bus.hmove_blank, m_blank, $time);
      end
   endtask

   // n ticks spaced 4 clocks apart.
   task automatic ticks(input int n, input logic [NUM_OBJ*HM_W-1:0] hmv, input string tag);
      for (int t = 0; t < n; t++) begin
         cycle(1'b1, 1'b0, 1'b0, hmv, tag);
         repeat (3) cycle(1'b0, 1'b0, 1'b0, hmv, tag);
      end
   endtask

   task automatic clear_counts();
      for (int i = 0; i < NUM_OBJ; i++) low_cnt[i] = 0;
   endtask

   task automatic test_reset();
      bus.tick = 1'b0; bus.hmove = 1'b0; bus.rhb = 1'b0; bus.hm = '0;
      m_active = 1'b0; m_cnt = 0; m_blank = 1'b0;
      for (int i = 0; i < NUM_OBJ; i++) m_pulses[i] = 0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.pec_bar !== 5'b11111 || bus.busy !== 1'b0 || bus.hmove_blank !== 1'b0) begin
         n_bad++;
         $display("FAIL reset: got pec=%b busy=%b blank=%b want 11111/0/0",
                  bus.pec_bar, bus.busy, bus.hmove_blank);
      end
      @(negedge clk);
      reset_bar = 1'b1;
      cycle(1'b1, 1'b0, 1'b0, '0, "idle_tick");
   endtask

   task automatic test_p0_max();
      logic [NUM_OBJ*HM_W-1:0] h;
      h = pack_hm(4'b0111, 4'b1000, 4'b1000, 4'b1000, 4'b1000);
      clear_counts();
      cycle(1'b0, 1'b1, 1'b0, h, "p0_max");
      ticks(20, h, "p0_max");
      n_cmp++;
      if (low_cnt[OBJ_P0] != 15) begin
         n_bad++; $display("FAIL p0_max count P0: got %0d want 15", low_cnt[OBJ_P0]);
      end
      n_cmp++;
      if (low_cnt[OBJ_P1] + low_cnt[OBJ_M0] + low_cnt[OBJ_M1] + low_cnt[OBJ_BL] != 0) begin
         n_bad++; $display("FAIL p0_max others: got %0d pulses want 0",
                           low_cnt[OBJ_P1] + low_cnt[OBJ_M0] + low_cnt[OBJ_M1] + low_cnt[OBJ_BL]);
      end
      n_cmp++;
      if (bus.busy !== 1'b0) begin
         n_bad++; $display("FAIL p0_max busy_end: got %b want 0", bus.busy);
      end
   endtask

   task automatic test_all_zero();
      logic [NUM_OBJ*HM_W-1:0] h;
      h = pack_hm(0, 0, 0, 0, 4'b1111);
      clear_counts();
      cycle(1'b0, 1'b1, 1'b0, h, "zero");
      ticks(17, h, "zero");
      for (int i = 0; i < NUM_OBJ; i++) begin
         n_cmp++;
         if (low_cnt[i] != ((i == int'(OBJ_BL)) ? 7 : 8)) begin
            n_bad++; $display("FAIL zero count obj%0d: got %0d want %0d", i, low_cnt[i],
                              (i == int'(OBJ_BL)) ? 7 : 8);
         end
      end
   endtask

   task automatic test_restart();
      logic [NUM_OBJ*HM_W-1:0] h1, h2;
      bit dropped;
      h1 = pack_hm(4'b0111, 4'b1000, 4'b1000, 4'b1000, 4'b1000);
      h2 = pack_hm(4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b1000);
      clear_counts();
      dropped = 1'b0;
      cycle(1'b0, 1'b1, 1'b0, h1, "restart");
      for (int t = 0; t < 5; t++) begin
         cycle(1'b1, 1'b0, 1'b0, h1, "restart");
         if (bus.busy !== 1'b1) dropped = 1'b1;
         repeat (3) begin
            cycle(1'b0, 1'b0, 1'b0, h1, "restart");
            if (bus.busy !== 1'b1) dropped = 1'b1;
         end
      end
      n_cmp++;
      if (low_cnt[OBJ_P0] != 5) begin
         n_bad++; $display("FAIL restart before: got %0d want 5", low_cnt[OBJ_P0]);
      end
      cycle(1'b0, 1'b1, 1'b0, h2, "restart");
      if (bus.busy !== 1'b1) dropped = 1'b1;
      for (int t = 0; t < 15; t++) begin
         cycle(1'b1, 1'b0, 1'b0, h2, "restart");
         if (bus.busy !== 1'b1) dropped = 1'b1;
         repeat (3) cycle(1'b0, 1'b0, 1'b0, h2, "restart");
      end
      ticks(2, h2, "restart");
      n_cmp++;
      if (low_cnt[OBJ_P0] != 13) begin
         n_bad++; $display("FAIL restart total: got %0d want 13", low_cnt[OBJ_P0]);
      end
      n_cmp++;
      if (dropped) begin
         n_bad++; $display("FAIL restart busy_cont: busy dropped got 0 want 1");
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [NUM_OBJ*HM_W-1:0] h;
      h = pack_hm(4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0111);
      clear_counts();
      cycle(1'b0, 1'b1, 1'b0, h, "midrst");
      ticks(2, h, "midrst");
      cycle(1'b1, 1'b0, 1'b0, h, "midrst");
      @(negedge clk);
      reset_bar = 1'b0;
      bus.tick = 1'b1;
      #1;
      n_cmp++;
      if (bus.pec_bar !== 5'b11111 || bus.busy !== 1'b0 || bus.hmove_blank !== 1'b0) begin
         n_bad++; $display("FAIL midrst async: got pec=%b busy=%b blank=%b want 11111/0/0",
                           bus.pec_bar, bus.busy, bus.hmove_blank);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.pec_bar !== 5'b11111) begin
         n_bad++; $display("FAIL midrst held: got %b want 11111", bus.pec_bar);
      end
      @(negedge clk);
      reset_bar = 1'b1;
      bus.tick = 1'b0;
      m_active = 1'b0; m_cnt = 0; m_blank = 1'b0;
      clear_counts();
      ticks(6, h, "midrst_after");
      n_cmp++;
      if (low_cnt[OBJ_P0] + low_cnt[OBJ_BL] != 0) begin
         n_bad++; $display("FAIL midrst after: got %0d pulses want 0", low_cnt[OBJ_P0] + low_cnt[OBJ_BL]);
      end
   endtask

   task automatic test_blank();
      logic [NUM_OBJ*HM_W-1:0] h;
      h = pack_hm(4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000);
      cycle(1'b0, 1'b1, 1'b1, h, "blank_both");
      n_cmp++;
      if (bus.hmove_blank !== 1'b1) begin
         n_bad++; $display("FAIL blank_both: got %b want 1", bus.hmove_blank);
      end
      repeat (3) cycle(1'b0, 1'b0, 1'b0, h, "blank_hold");
      cycle(1'b0, 1'b0, 1'b1, h, "blank_clr");
      n_cmp++;
      if (bus.hmove_blank !== 1'b0) begin
         n_bad++; $display("FAIL blank_clr: got %b want 0", bus.hmove_blank);
      end
      cycle(1'b0, 1'b0, 1'b1, h, "blank_lone");
      ticks(17, h, "blank_drain");
   endtask

   task automatic test_coincident();
      logic [NUM_OBJ*HM_W-1:0] h;
      h = pack_hm(4'b1000, 4'b1001, 4'b1000, 4'b1000, 4'b1000);
      clear_counts();
      cycle(1'b1, 1'b1, 1'b0, h, "coinc");
      n_cmp++;
      if (bus.pec_bar !== 5'b11111) begin
         n_bad++; $display("FAIL coinc same_cycle: got %b want 11111", bus.pec_bar);
      end
      repeat (3) cycle(1'b0, 1'b0, 1'b0, h, "coinc");
      for (int t = 0; t < 17; t++) begin
         h = NUM_OBJ*HM_W'($urandom);
         cycle(1'b1, 1'b0, 1'b0, h, "coinc_chg");
         repeat (3) cycle(1'b0, 1'b0, 1'b0, h, "coinc_chg");
      end
      n_cmp++;
      if (low_cnt[OBJ_P1] != 1 || low_cnt[OBJ_P0] + low_cnt[OBJ_M0] + low_cnt[OBJ_M1] + low_cnt[OBJ_BL] != 0) begin
         n_bad++; $display("FAIL coinc counts: got P1=%0d others=%0d want 1/0", low_cnt[OBJ_P1],
                           low_cnt[OBJ_P0] + low_cnt[OBJ_M0] + low_cnt[OBJ_M1] + low_cnt[OBJ_BL]);
      end
   endtask

   task automatic test_random();
      logic [NUM_OBJ*HM_W-1:0] h;
      bit tk, hv, rb;
      int phase;
      phase = int'($urandom_range(0, 3));
      for (int c = 0; c < 1500; c++) begin
         h  = NUM_OBJ*HM_W'($urandom);
         tk = ((c % 4) == phase);
         hv = ($urandom_range(0, 79) == 0);
         rb = ($urandom_range(0, 19) == 0);
         cycle(tk, hv, rb, h, "random");
      end
   endtask

   initial begin
      test_reset();
      test_p0_max();
      test_all_zero();
      test_restart();
      test_reset_mid_burst();
      test_blank();
      test_coincident();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
